// File: rtl/ifu_pkg.sv
// Shared types and constants for the prefetching instruction-fetch unit.
package ifu_pkg;

  // Fetch sequencer states: RUN may issue, WAIT holds one live request,
  // DROP holds one request whose response must be thrown away.
  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } ifu_state_e;

  localparam int unsigned INST_W       = 32;
  localparam logic [31:0] IFU_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/ifu_fifo.sv
// Show-ahead FIFO with synchronous flush; head entry is visible while count > 0.
module ifu_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign do_pop    = pop & ~empty;
  assign do_push   = push & (~full | do_pop);
  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

  // Next-state for storage, pointers and occupancy; flush wins over push/pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction fetch with prefetch FIFO, single outstanding memory request and
// redirect-driven flush. Decode sees a valid/ready stream of {pc, inst, pc+8}.
module ifu_prefetch
  import ifu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IFU_RESET_PC)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              gp_branch,
  input  logic              fp_branch,
  input  logic              jump,
  input  logic              use_reg,
  input  logic [ADDR_W-1:0] target_pc,
  input  logic [ADDR_W-1:0] pc_from_reg,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [INST_W-1:0] mem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_8_out
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned ENT_W = ADDR_W + INST_W;

  ifu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              mem_req_q, mem_req_d;

  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              accept;
  logic              outstanding;
  logic              fifo_push;
  logic              fifo_pop;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  count_nxt;
  logic [ENT_W-1:0]  head;
  logic [ADDR_W-1:0] head_pc;

  assign redirect    = use_reg | jump | gp_branch | fp_branch;
  assign accept      = mem_req_q & mem_ready;
  assign outstanding = (state_q != ST_RUN);
  assign inst_valid  = (fifo_count != '0);

  // Redirect target: register jumps take priority; word-align the result.
  always_comb begin
    redirect_pc = use_reg ? pc_from_reg : target_pc;
    redirect_pc = redirect_pc & ~ADDR_W'(3);
  end

  // Redirect suppresses both push and pop; the FIFO is flushed instead.
  assign fifo_push = ~redirect & (state_q == ST_WAIT) & mem_rvalid;
  assign fifo_pop  = ~redirect & inst_valid & inst_ready;

  ifu_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clock),
    .rst_n     (reset),
    .push      (fifo_push),
    .push_data ({fetch_pc_q, mem_rdata}),
    .pop       (fifo_pop),
    .flush     (redirect),
    .head_data (head),
    .count     (fifo_count)
  );

  // Occupancy after this edge, used to decide next cycle's request.
  always_comb begin
    count_nxt = fifo_count;
    if (redirect) begin
      count_nxt = '0;
    end else begin
      unique case ({fifo_push, fifo_pop})
        2'b10:   count_nxt = fifo_count + CNT_W'(1);
        2'b01:   count_nxt = fifo_count - CNT_W'(1);
        default: count_nxt = fifo_count;
      endcase
    end
  end

  // Fetch sequencer next state. A redirect with a request still in flight
  // (including one accepted this very cycle) must swallow its response.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      if ((outstanding & ~mem_rvalid) | accept) begin
        state_d = ST_DROP;
      end else begin
        state_d = ST_RUN;
      end
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (accept) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(4);
            state_d    = ST_RUN;
          end
        end
        ST_DROP: begin
          if (mem_rvalid) state_d = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end
    // Request is registered: raise it for the next cycle only when the
    // sequencer will be idle and the FIFO will have room.
    mem_req_d = (state_d == ST_RUN) && (count_nxt < CNT_W'(DEPTH));
  end

  // Sequencer registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= RESET_PC;
      mem_req_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_req_q  <= mem_req_d;
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = fetch_pc_q;

  assign head_pc  = head[ENT_W-1:INST_W];
  assign inst_out = inst_valid ? head[INST_W-1:0] : '0;
  assign pc_out   = inst_valid ? head_pc : '0;
  assign pc_8_out = inst_valid ? (head_pc + ADDR_W'(8)) : '0;

endmodule

// File: tb/tb_ifu_prefetch.sv
// Randomized bench for ifu_prefetch against a transaction-level reference model.
module tb_ifu_prefetch;

  localparam int DEP = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (32-bit addresses)
  logic        rst_n;
  logic        gp_branch, fp_branch, jump, use_reg;
  logic [31:0] target_pc, pc_from_reg;
  logic        mem_req, mem_ready, mem_rvalid;
  logic [31:0] mem_addr, mem_rdata;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_out, pc_out, pc_8_out;

  ifu_prefetch #(.ADDR_W(32), .DEPTH(DEP), .RESET_PC(32'h0)) dut (
    .clock(clk), .reset(rst_n),
    .gp_branch(gp_branch), .fp_branch(fp_branch), .jump(jump), .use_reg(use_reg),
    .target_pc(target_pc), .pc_from_reg(pc_from_reg),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_out(inst_out), .pc_out(pc_out), .pc_8_out(pc_8_out)
  );

  // Narrow DUT for address wraparound
  logic        rst_b;
  logic        mem_req_b, mem_rvalid_b, inst_valid_b;
  logic [7:0]  mem_addr_b, pc_out_b, pc_8_out_b;
  logic [31:0] mem_rdata_b, inst_out_b;

  ifu_prefetch #(.ADDR_W(8), .DEPTH(DEP), .RESET_PC(8'hF8)) dut_b (
    .clock(clk), .reset(rst_b),
    .gp_branch(1'b0), .fp_branch(1'b0), .jump(1'b0), .use_reg(1'b0),
    .target_pc(8'h00), .pc_from_reg(8'h00),
    .mem_req(mem_req_b), .mem_addr(mem_addr_b), .mem_ready(1'b1),
    .mem_rvalid(mem_rvalid_b), .mem_rdata(mem_rdata_b),
    .inst_valid(inst_valid_b), .inst_ready(1'b1),
    .inst_out(inst_out_b), .pc_out(pc_out_b), .pc_8_out(pc_8_out_b)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Reference model: expected decode queue, next fetch address, and the
  // single in-flight memory request (live or already superseded).
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        q[$];
  logic [31:0] exp_addr;
  bit          pend, pend_live;
  logic [31:0] pend_addr, pend_env_addr;
  int unsigned pend_cd;

  int unsigned p_ready, p_iready, p_redir, p_spur, max_lat;
  bit          force_en, force_iready;
  logic [3:0]  force_flags;
  logic [31:0] force_tgt, force_pfr;

  task automatic model_reset();
    q.delete();
    exp_addr  = 32'h0;
    pend      = 1'b0;
    pend_live = 1'b0;
    pend_cd   = 0;
  endtask

  task automatic drive_idle();
    {use_reg, jump, gp_branch, fp_branch} = 4'b0;
    target_pc   = '0;
    pc_from_reg = '0;
    mem_ready   = 1'b0;
    mem_rvalid  = 1'b0;
    mem_rdata   = '0;
    inst_ready  = 1'b0;
  endtask

  // Called at a falling edge: check outputs, drive inputs, advance model
  // across the coming rising edge.
  task automatic step();
    logic        redir;
    logic [31:0] tgt;
    bit          acc, resp, pop, exp_req;
    int unsigned kind;
    exp_req = !pend && (q.size() < DEP);
    chk_eq("inst_valid", 64'(inst_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      chk_eq("pc_out",   64'(pc_out),   64'(q[0].pc));
      chk_eq("inst_out", 64'(inst_out), 64'(q[0].inst));
      chk_eq("pc_8_out", 64'(pc_8_out), 64'(q[0].pc + 32'd8));
    end else begin
      chk_eq("idle_data", {inst_out, pc_out}, 64'h0);
      chk_eq("idle_pc8",  64'(pc_8_out), 64'h0);
    end
    chk_eq("mem_req", 64'(mem_req), 64'(exp_req));
    if (mem_req) chk_eq("mem_addr", 64'(mem_addr), 64'(exp_addr));

    mem_ready = (($urandom % 100) < p_ready);
    if (pend && pend_cd == 0) begin
      mem_rvalid = 1'b1;
      mem_rdata  = mem_word(pend_env_addr);
    end else begin
      mem_rvalid = !pend && (($urandom % 100) < p_spur);
      mem_rdata  = $urandom;
    end
    inst_ready  = force_iready || (($urandom % 100) < p_iready);
    target_pc   = $urandom;
    pc_from_reg = $urandom;
    {use_reg, jump, gp_branch, fp_branch} = 4'b0;
    if (force_en) begin
      {use_reg, jump, gp_branch, fp_branch} = force_flags;
      target_pc   = force_tgt;
      pc_from_reg = force_pfr;
    end else if (($urandom % 100) < p_redir) begin
      kind = $urandom % 4;
      {use_reg, jump, gp_branch, fp_branch} = 4'b1000 >> kind;
      if (($urandom % 4) == 0) gp_branch = 1'b1;
    end
    force_en     = 1'b0;
    force_iready = 1'b0;

    redir = use_reg | jump | gp_branch | fp_branch;
    tgt   = (use_reg ? pc_from_reg : target_pc) & 32'hFFFF_FFFC;
    acc   = mem_req && mem_ready;
    resp  = mem_rvalid && pend;
    pop   = (q.size() > 0) && inst_ready && !redir;

    if (pop) void'(q.pop_front());
    if (resp) begin
      if (pend_live && !redir) q.push_back('{pc: pend_addr, inst: mem_word(pend_addr)});
      pend = 1'b0;
    end else if (pend && pend_cd > 0) begin
      pend_cd--;
    end
    if (acc) begin
      pend          = 1'b1;
      pend_live     = !redir;
      pend_addr     = exp_addr;
      pend_env_addr = mem_addr;
      pend_cd       = $urandom_range(max_lat - 1, 0);
      if (!redir) exp_addr = exp_addr + 32'd4;
    end
    if (redir) begin
      q.delete();
      exp_addr  = tgt;
      pend_live = 1'b0;
    end
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      step();
      @(negedge clk);
    end
  endtask

  task automatic reset_checks();
    chk_eq("rst_mem_req",    64'(mem_req),    64'h0);
    chk_eq("rst_mem_addr",   64'(mem_addr),   64'h0);
    chk_eq("rst_inst_valid", 64'(inst_valid), 64'h0);
    chk_eq("rst_data",       {inst_out, pc_out}, 64'h0);
    chk_eq("rst_pc8",        64'(pc_8_out),   64'h0);
  endtask

  // Asynchronous reset mid-cycle, ideally with a request in flight and two
  // buffered entries; memory is reset alongside.
  task automatic mid_reset();
    p_iready = 10;
    p_redir  = 0;
    for (int unsigned i = 0; i < 300 && !(pend && q.size() == 2); i++) begin
      step();
      @(negedge clk);
    end
    step();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    reset_checks();
    drive_idle();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_req(input string tag, input logic [31:0] want);
    bit seen;
    seen = 1'b0;
    for (int unsigned i = 0; i < 30 && !seen; i++) begin
      if (mem_req) begin
        seen = 1'b1;
        chk_eq(tag, 64'(mem_addr), 64'(want));
      end else begin
        step();
        @(negedge clk);
      end
    end
    if (!seen) chk_eq({tag, "_timeout"}, 64'h0, 64'h1);
  endtask

  bit done_b = 1'b0;

  // Wraparound stream on the narrow instance: one-cycle memory, always ready.
  initial begin
    bit          pend_b;
    logic [7:0]  pa_b, want;
    int unsigned n;
    rst_b        = 1'b0;
    mem_rvalid_b = 1'b0;
    mem_rdata_b  = '0;
    pend_b       = 1'b0;
    pa_b         = '0;
    n            = 0;
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    for (int unsigned c = 0; c < 60 && n < 4; c++) begin
      @(negedge clk);
      if (inst_valid_b) begin
        want = 8'hF8 + 8'(4 * n);
        chk_eq("wrap_pc",   64'(pc_out_b),   64'(want));
        chk_eq("wrap_pc8",  64'(pc_8_out_b), 64'(8'(want + 8'd8)));
        chk_eq("wrap_inst", 64'(inst_out_b), 64'({24'h0, want}));
        n++;
      end
      mem_rvalid_b = pend_b;
      mem_rdata_b  = {24'h0, pa_b};
      pend_b       = mem_req_b;
      pa_b         = mem_addr_b;
    end
    if (n < 4) chk_eq("wrap_timeout", 64'(n), 64'd4);
    done_b = 1'b1;
  end

  initial begin
    drive_idle();
    model_reset();
    force_en     = 1'b0;
    force_iready = 1'b0;
    force_flags  = '0;
    force_tgt    = '0;
    force_pfr    = '0;
    rst_n        = 1'b0;
    repeat (3) @(negedge clk);
    reset_checks();
    rst_n = 1'b1;
    @(negedge clk);

    // Fill with decode stalled, release one entry, then stream.
    p_ready = 100; p_iready = 0; p_redir = 0; p_spur = 0; max_lat = 1;
    run(20);
    force_iready = 1'b1;
    run(6);
    p_iready = 100;
    run(40);

    // Jump while a slow request is in flight.
    max_lat = 3; p_iready = 50;
    for (int unsigned i = 0; i < 50 && !(pend && pend_cd > 0); i++) run(1);
    force_en = 1'b1; force_flags = 4'b0100; force_tgt = 32'h103; force_pfr = 32'h0;
    run(1);
    wait_req("jump_target", 32'h100);
    run(10);

    // Register jump beats simultaneous branch.
    force_en = 1'b1; force_flags = 4'b1010; force_tgt = 32'h80; force_pfr = 32'h40;
    run(1);
    wait_req("jr_target", 32'h40);

    // Redirect coinciding with a response and a pop.
    max_lat = 1; p_ready = 100; p_iready = 0;
    for (int unsigned i = 0; i < 60 && !(pend && pend_cd == 0 && q.size() > 0); i++) run(1);
    force_en = 1'b1; force_iready = 1'b1; force_flags = 4'b0100; force_tgt = 32'h200;
    run(1);
    chk_eq("coinc_empty", 64'(inst_valid), 64'h0);

    // Randomized traffic interleaved with asynchronous resets.
    for (int unsigned r = 0; r < 3; r++) begin
      p_ready = 60; p_iready = 60; p_redir = 6; p_spur = 10; max_lat = 4;
      run(600);
      mid_reset();
    end
    p_ready = 80; p_iready = 70; p_redir = 3; p_spur = 5; max_lat = 2;
    run(200);

    for (int unsigned i = 0; i < 100 && !done_b; i++) @(negedge clk);
    if (!done_b) chk_eq("wrap_done", 64'h0, 64'h1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
